// File: rtl/fetch_prefetch_if.sv
// Fetch front-end bus bundle: instruction-memory req/ack channel plus the
// valid/ready channel toward the fetch/decode register.
interface fetch_prefetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready;

  modport master (
    output imem_req, imem_addr, out_valid, out_instr, out_pc,
    input  imem_ack, imem_rdata, out_ready
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_instr, out_pc,
    output imem_ack, imem_rdata, out_ready
  );
endinterface

// File: rtl/fetch_prefetch.sv
// Instruction-fetch front end: owns the fetch PC, issues one outstanding imem
// request at a time, and buffers {pc, instr} pairs in a small prefetch FIFO.
module fetch_prefetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  fetch_prefetch_if.master        bus,
  input  logic                    redirect,
  input  logic [31:0]             redirect_pc,
  output logic [$clog2(DEPTH):0]  fifo_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   req_addr_q, req_addr_d;
  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          imem_req_q, imem_req_d;
  logic          out_valid_q, out_valid_d;

  logic          push_c;
  logic          pop_c;
  logic [CW-1:0] count_nx_c;
  logic          room_c;

  // Next-state: redirect overrides everything; otherwise FIFO update + FSM.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    for (int i = 0; i < int'(DEPTH); i++) mem_d[i] = mem_q[i];

    push_c     = (state_q == WAIT) && bus.imem_ack;
    pop_c      = out_valid_q && bus.out_ready;
    count_nx_c = count_q + CW'(push_c) - CW'(pop_c);
    room_c     = (count_nx_c < CW'(DEPTH));

    if (redirect) begin
      fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      // A request still waiting for its ack must drain in DROP first.
      if ((state_q != IDLE) && !bus.imem_ack) begin
        state_d = DROP;
      end else begin
        state_d    = WAIT;
        req_addr_d = redirect_pc & 32'hFFFF_FFFC;
      end
    end else begin
      count_d = count_nx_c;
      if (push_c) begin
        mem_d[wr_ptr_q] = '{pc: fetch_pc_q, instr: bus.imem_rdata};
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop_c) rd_ptr_d = rd_ptr_q + PW'(1);

      case (state_q)
        IDLE: begin
          if (room_c) begin
            state_d    = WAIT;
            req_addr_d = fetch_pc_q;
          end
        end
        WAIT: begin
          if (bus.imem_ack) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            if (room_c) req_addr_d = fetch_pc_q + 32'd4;
            else        state_d    = IDLE;
          end
        end
        DROP: begin
          if (bus.imem_ack) begin
            state_d    = WAIT;
            req_addr_d = fetch_pc_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    imem_req_d  = (state_d != IDLE);
    out_valid_d = (count_d != '0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      fetch_pc_q  <= RESET_PC;
      req_addr_q  <= RESET_PC;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      imem_req_q  <= 1'b0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      req_addr_q  <= req_addr_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      imem_req_q  <= imem_req_d;
      out_valid_q <= out_valid_d;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= mem_d[i];
    end
  end

  assign bus.imem_req  = imem_req_q;
  assign bus.imem_addr = req_addr_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_instr = mem_q[rd_ptr_q].instr;
  assign bus.out_pc    = mem_q[rd_ptr_q].pc;
  assign fifo_count    = count_q;

endmodule

// File: tb/tb_fetch_prefetch.sv
// Directed bench for fetch_prefetch: a per-cycle vector table plus hand-written
// sequences for latency/redirect, reset-during-request and PC wrap.
module tb_fetch_prefetch;

  logic        clock = 1'b0;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [2:0]  fifo_count;
  logic [2:0]  fifo_count2;

  logic        tb_ack, tb_rdy, mdl_ack, mem_auto;
  int          mem_lat, wcnt;
  int          total, bad;

  fetch_prefetch_if bus ();
  fetch_prefetch_if bus2 ();

  assign bus.imem_ack    = mem_auto ? mdl_ack : tb_ack;
  assign bus.imem_rdata  = bus.imem_addr;
  assign bus.out_ready   = tb_rdy;
  assign bus2.imem_ack   = bus2.imem_req;
  assign bus2.imem_rdata = bus2.imem_addr;
  assign bus2.out_ready  = 1'b1;

  fetch_prefetch #(.RESET_PC(32'h0000_0000), .DEPTH(4)) u_dut (
    .clock(clock), .reset(reset), .bus(bus.master),
    .redirect(redirect), .redirect_pc(redirect_pc), .fifo_count(fifo_count));

  fetch_prefetch #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) u_wrap (
    .clock(clock), .reset(reset), .bus(bus2.master),
    .redirect(1'b0), .redirect_pc(32'h0), .fifo_count(fifo_count2));

  always #5 clock = ~clock;

  // Latency memory: acks after mem_lat idle cycles of a held request.
  always @(negedge clock) begin
    if (!bus.imem_req) begin
      mdl_ack <= 1'b0;
      wcnt    <= 0;
    end else if (wcnt >= mem_lat) begin
      mdl_ack <= 1'b1;
      wcnt    <= 0;
    end else begin
      mdl_ack <= 1'b0;
      wcnt    <= wcnt + 1;
    end
  end

  typedef struct {
    logic        rst, rdy, ack, redir;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [2:0]  e_cnt;
  } vec_t;

  localparam int NV = 28;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  task automatic sv(input int i, input logic rst, input logic rdy, input logic ack,
                    input logic redir, input logic [31:0] rpc, input logic req,
                    input logic [31:0] addr, input logic valid, input logic [31:0] pc,
                    input logic [2:0] cnt);
    vecs[i] = '{rst, rdy, ack, redir, rpc, req, addr, valid, pc, cnt};
  endtask

  // Hold reset two edges, then release at a negedge: returns in cycle 0.
  task automatic do_reset();
    mem_auto = 1'b0; tb_ack = 1'b0; tb_rdy = 1'b1; redirect = 1'b0;
    reset = 1'b1;
    @(posedge clock); @(posedge clock); @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic        seen_addr;
    logic [31:0] next_addr;
    logic        got_valid;
    string       nm;

    total = 0; bad = 0;
    mem_lat = 0; mem_auto = 1'b0;
    tb_ack = 1'b0; tb_rdy = 1'b0; redirect = 1'b0; redirect_pc = '0;
    reset = 1'b1;

    //  i  rst rdy ack rd  rpc             req addr            v  pc             cnt
    sv( 0, 0, 0, 0, 0, 32'h0,          0, 32'h0,          0, 32'h0,   0);
    sv( 1, 0, 0, 1, 0, 32'h0,          1, 32'h0,          0, 32'h0,   0);
    sv( 2, 0, 0, 1, 0, 32'h0,          1, 32'h4,          1, 32'h0,   1);
    sv( 3, 0, 0, 1, 0, 32'h0,          1, 32'h8,          1, 32'h0,   2);
    sv( 4, 0, 0, 1, 0, 32'h0,          1, 32'hC,          1, 32'h0,   3);
    sv( 5, 0, 0, 0, 0, 32'h0,          0, 32'hC,          1, 32'h0,   4);
    sv( 6, 0, 1, 0, 0, 32'h0,          0, 32'hC,          1, 32'h0,   4);
    sv( 7, 0, 1, 1, 0, 32'h0,          1, 32'h10,         1, 32'h4,   3);
    sv( 8, 0, 1, 1, 0, 32'h0,          1, 32'h14,         1, 32'h8,   3);
    sv( 9, 0, 1, 1, 0, 32'h0,          1, 32'h18,         1, 32'hC,   3);
    sv(10, 0, 1, 1, 0, 32'h0,          1, 32'h1C,         1, 32'h10,  3);
    sv(11, 1, 1, 0, 0, 32'h0,          1, 32'h20,         1, 32'h14,  3);
    sv(12, 0, 1, 0, 0, 32'h0,          0, 32'h0,          0, 32'h0,   0);
    sv(13, 0, 1, 1, 0, 32'h0,          1, 32'h0,          0, 32'h0,   0);
    sv(14, 0, 1, 1, 0, 32'h0,          1, 32'h4,          1, 32'h0,   1);
    sv(15, 0, 1, 1, 0, 32'h0,          1, 32'h8,          1, 32'h4,   1);
    sv(16, 0, 1, 1, 0, 32'h0,          1, 32'hC,          1, 32'h8,   1);
    sv(17, 0, 0, 1, 0, 32'h0,          1, 32'h10,         1, 32'hC,   1);
    sv(18, 0, 0, 1, 1, 32'h200,        1, 32'h14,         1, 32'hC,   2);
    sv(19, 0, 1, 1, 0, 32'h0,          1, 32'h200,        0, 32'h0,   0);
    sv(20, 0, 1, 1, 0, 32'h0,          1, 32'h204,        1, 32'h200, 1);
    sv(21, 0, 1, 0, 0, 32'h0,          1, 32'h208,        1, 32'h204, 1);
    sv(22, 0, 1, 0, 1, 32'h303,        1, 32'h208,        0, 32'h0,   0);
    sv(23, 0, 1, 0, 1, 32'h402,        1, 32'h208,        0, 32'h0,   0);
    sv(24, 0, 1, 1, 0, 32'h0,          1, 32'h208,        0, 32'h0,   0);
    sv(25, 0, 1, 1, 0, 32'h0,          1, 32'h400,        0, 32'h0,   0);
    sv(26, 0, 1, 0, 0, 32'h0,          1, 32'h404,        1, 32'h400, 1);
    sv(27, 0, 1, 0, 0, 32'h0,          1, 32'h404,        0, 32'h0,   0);

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset out_pc", bus.out_pc, 32'h0);
    chk("reset out_instr", bus.out_instr, 32'h0);

    // Table: check this cycle's outputs, then drive this cycle's inputs.
    for (int i = 0; i < NV; i++) begin
      if (i > 0) @(negedge clock);
      nm = $sformatf("v%0d", i);
      chk({nm, " imem_req"},   32'(bus.imem_req),  32'(vecs[i].e_req));
      chk({nm, " imem_addr"},  bus.imem_addr,      vecs[i].e_addr);
      chk({nm, " out_valid"},  32'(bus.out_valid), 32'(vecs[i].e_valid));
      chk({nm, " fifo_count"}, 32'(fifo_count),    32'(vecs[i].e_cnt));
      if (vecs[i].e_valid) begin
        chk({nm, " out_pc"},    bus.out_pc,    vecs[i].e_pc);
        chk({nm, " out_instr"}, bus.out_instr, vecs[i].e_pc);
      end
      reset       = vecs[i].rst;
      tb_rdy      = vecs[i].rdy;
      tb_ack      = vecs[i].ack;
      redirect    = vecs[i].redir;
      redirect_pc = vecs[i].rpc;
    end

    // Slow memory, redirect one cycle after req rises: stale word is dropped.
    do_reset();
    mem_lat = 3; mem_auto = 1'b1;
    @(negedge clock);
    chk("lat req rises", 32'(bus.imem_req), 32'd1);
    @(negedge clock);
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    @(negedge clock);
    redirect = 1'b0;
    chk("lat count after redirect", 32'(fifo_count), 32'd0);
    chk("lat valid after redirect", 32'(bus.out_valid), 32'd0);
    chk("lat stale addr held", bus.imem_addr, 32'h0);
    seen_addr = 1'b0; next_addr = '0; got_valid = 1'b0;
    for (int k = 0; k < 30 && !got_valid; k++) begin
      @(negedge clock);
      if (!seen_addr && bus.imem_addr != 32'h0) begin
        seen_addr = 1'b1;
        next_addr = bus.imem_addr;
      end
      if (bus.out_valid) got_valid = 1'b1;
    end
    chk("lat valid within budget", 32'(got_valid), 32'd1);
    chk("lat next imem_addr", next_addr, 32'h0000_0100);
    chk("lat first out_pc", bus.out_pc, 32'h0000_0100);
    chk("lat first out_instr", bus.out_instr, 32'h0000_0100);

    // Reset while waiting; the late ack lands in IDLE and must be ignored.
    do_reset();
    @(negedge clock);
    chk("rst-wait req", 32'(bus.imem_req), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    chk("rst-wait req dropped", 32'(bus.imem_req), 32'd0);
    reset = 1'b0; tb_ack = 1'b1;
    @(negedge clock);
    tb_ack = 1'b0;
    chk("rst-wait valid", 32'(bus.out_valid), 32'd0);
    chk("rst-wait count", 32'(fifo_count), 32'd0);
    chk("rst-wait restart req", 32'(bus.imem_req), 32'd1);
    chk("rst-wait restart addr", bus.imem_addr, 32'h0);
    @(negedge clock);
    chk("rst-wait valid later", 32'(bus.out_valid), 32'd0);

    // PC wrap on the second instance (zero-wait, always ready).
    do_reset();
    @(negedge clock);
    @(negedge clock);
    chk("wrap valid c2", 32'(bus2.out_valid), 32'd1);
    chk("wrap pc c2", bus2.out_pc, 32'hFFFF_FFF8);
    @(negedge clock);
    chk("wrap pc c3", bus2.out_pc, 32'hFFFF_FFFC);
    chk("wrap instr c3", bus2.out_instr, 32'hFFFF_FFFC);
    @(negedge clock);
    chk("wrap pc c4", bus2.out_pc, 32'h0000_0000);
    chk("wrap valid c4", 32'(bus2.out_valid), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
